// File: rtl/nibble_serial_sub.sv
// Nibble-serial WIDTH-bit subtractor: one 4-bit carry-lookahead slice per clock, LSB nibble first.
// Optional build macro NSUB_SAT_EN saturates d to the signed limit on overflow.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / 4;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh_p0, b_sh_p0;
  logic [WIDTH-5:0] res_sh_p0;
  logic             a_msb_p0, b_msb_p0;
  logic             carry_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             accept, last;
  logic [4:0]       slice;
  logic [WIDTH-1:0] d_wrap, d_fin;
  logic             ovf;

  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
    logic [3:0] g, p, c;
    logic       c4;
    g    = x & y;
    p    = x ^ y;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, p ^ c};
  endfunction

`ifdef NSUB_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_lim(input logic neg);
    logic signed [WIDTH-1:0] lim;
    lim = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return lim;
  endfunction
`endif

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt_p0 == LAST);
  assign slice  = cla4(a_sh_p0[3:0], ~b_sh_p0[3:0], carry_p0);
  assign d_wrap = {slice[3:0], res_sh_p0};
  assign ovf    = (a_msb_p0 ^ b_msb_p0) & (d_wrap[WIDTH-1] ^ a_msb_p0);

`ifdef NSUB_SAT_EN
  assign d_fin = ovf ? sat_lim(a_msb_p0) : d_wrap;
`else
  assign d_fin = d_wrap;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt_p0 == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // control and result registers: reset to their architectural values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      carry_p0 <= 1'b0;
      cnt_p0   <= '0;
      d        <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
    end else begin
      state <= state_nx;
      if (accept) begin
        carry_p0 <= 1'b1;
        cnt_p0   <= '0;
      end else if (state == RUN) begin
        carry_p0 <= slice[4];
        cnt_p0   <= cnt_p0 + 1'b1;
      end
      if (last) begin
        d        <= d_fin;
        borrow   <= ~slice[4];
        overflow <= ovf;
        zero     <= (d_fin == '0);
      end
    end
  end

  // operand and partial-result shifters: contents are don't-care outside RUN
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh_p0  <= a;
      b_sh_p0  <= b;
      a_msb_p0 <= a[WIDTH-1];
      b_msb_p0 <= b[WIDTH-1];
    end else if (state == RUN) begin
      a_sh_p0   <= a_sh_p0 >> 4;
      b_sh_p0   <= b_sh_p0 >> 4;
      res_sh_p0 <= d_wrap[WIDTH-1:4];
    end
  end

endmodule
